// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared types and constants for the oscilloscope measurement path
package osc_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_HIGH_FIRST,
    COUNT_LOW,
    COUNT_HIGH
  } cross_state_t;

endpackage

// File: rtl/crossing_period.sv
// rtl/crossing_period.sv - hysteretic rising-crossing detector and period counter
module crossing_period
  import osc_pkg::*;
#(
  parameter logic [11:0] HYST = 12'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  input  logic [ADC_W-1:0] level,
  output logic [15:0]      period,
  output logic             period_valid
);

  cross_state_t     state, state_nxt;
  logic [15:0]      pcnt, pcnt_nxt, period_nxt;
  logic             period_valid_nxt;
  logic [ADC_W:0]   lo_diff, hi_sum;
  logic [ADC_W-1:0] lo_th, hi_th;
  logic             is_low, is_high, timeout;

  // Thresholds saturate at the ADC code range instead of wrapping.
  always_comb begin
    lo_diff = {1'b0, level} - {1'b0, HYST};
    hi_sum  = {1'b0, level} + {1'b0, HYST};
    lo_th   = lo_diff[ADC_W] ? '0 : lo_diff[ADC_W-1:0];
    hi_th   = hi_sum[ADC_W]  ? '1 : hi_sum[ADC_W-1:0];
    is_low  = (sample <= lo_th);
    is_high = (sample >= hi_th);
    timeout = (pcnt == 16'hFFFF);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= WAIT_LOW;
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      pcnt         <= pcnt_nxt;
      period       <= period_nxt;
      period_valid <= period_valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sample_valid) begin
      case (state)
        WAIT_LOW:        if (is_low)  state_nxt = WAIT_HIGH_FIRST;
        WAIT_HIGH_FIRST: if (is_high) state_nxt = COUNT_LOW;
        COUNT_LOW:       if (timeout) state_nxt = WAIT_LOW;
                         else if (is_low) state_nxt = COUNT_HIGH;
        COUNT_HIGH:      if (timeout) state_nxt = WAIT_LOW;
                         else if (is_high) state_nxt = COUNT_LOW;
        default:         state_nxt = WAIT_LOW;
      endcase
    end
  end

  // The crossing sample itself restarts pcnt at 1, so period is the sample distance.
  always_comb begin
    pcnt_nxt         = pcnt;
    period_nxt       = period;
    period_valid_nxt = period_valid;
    if (sample_valid) begin
      case (state)
        WAIT_HIGH_FIRST: if (is_high) pcnt_nxt = 16'd1;
        COUNT_LOW, COUNT_HIGH: begin
          if (timeout) begin
            pcnt_nxt         = '0;
            period_nxt       = '0;
            period_valid_nxt = 1'b0;
          end else if (state == COUNT_HIGH && is_high) begin
            period_nxt       = pcnt;
            period_valid_nxt = 1'b1;
            pcnt_nxt         = 16'd1;
          end else begin
            pcnt_nxt = pcnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/signal_meas.sv
// rtl/signal_meas.sv - windowed min/max/p2p/average statistics plus period measurement
module signal_meas
  import osc_pkg::*;
#(
  parameter int          WINDOW = 256,
  parameter logic [11:0] HYST   = 12'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  input  logic [ADC_W-1:0] level,
  output logic [ADC_W-1:0] min,
  output logic [ADC_W-1:0] max,
  output logic [ADC_W-1:0] p2p,
  output logic [ADC_W-1:0] average,
  output logic [15:0]      period,
  output logic             period_valid,
  output logic             meas_valid
);

  localparam int LOG2  = $clog2(WINDOW);
  localparam int SUM_W = ADC_W + LOG2;

  logic [LOG2-1:0]  cnt;
  logic [SUM_W-1:0] sum, nxt_sum;
  logic [ADC_W-1:0] run_min, run_max, nxt_min, nxt_max;
  logic             first, last;

  // The first sample of a window seeds the running values instead of comparing to stale ones.
  always_comb begin
    first   = (cnt == '0);
    last    = (cnt == LOG2'(WINDOW - 1));
    nxt_min = (first || sample < run_min) ? sample : run_min;
    nxt_max = (first || sample > run_max) ? sample : run_max;
    nxt_sum = first ? SUM_W'(sample) : sum + SUM_W'(sample);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      sum        <= '0;
      run_min    <= '0;
      run_max    <= '0;
      min        <= '0;
      max        <= '0;
      p2p        <= '0;
      average    <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (sample_valid) begin
        cnt     <= cnt + LOG2'(1);
        sum     <= nxt_sum;
        run_min <= nxt_min;
        run_max <= nxt_max;
        if (last) begin
          min        <= nxt_min;
          max        <= nxt_max;
          p2p        <= nxt_max - nxt_min;
          average    <= nxt_sum[SUM_W-1:LOG2];
          meas_valid <= 1'b1;
        end
      end
    end
  end

  crossing_period #(
    .HYST(HYST)
  ) u_cross (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .period       (period),
    .period_valid (period_valid)
  );

endmodule

// File: tb/tb_signal_meas.sv
// tb/tb_signal_meas.sv - directed self-checking bench for signal_meas
module tb_signal_meas;
  import osc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic [11:0] level = 12'd2000;
  logic [11:0] min_o, max_o, p2p_o, avg_o;
  logic [15:0] period_o;
  logic        period_valid_o, meas_valid_o;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pulse_base;

  signal_meas #(.WINDOW(16), .HYST(12'd16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .min          (min_o),
    .max          (max_o),
    .p2p          (p2p_o),
    .average      (avg_o),
    .period       (period_o),
    .period_valid (period_valid_o),
    .meas_valid   (meas_valid_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (meas_valid_o === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] v);
    @(negedge clk);
    sample_valid = 1'b1;
    sample = v;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_min", min_o, 0);
    chk("rst_max", max_o, 0);
    chk("rst_p2p", p2p_o, 0);
    chk("rst_avg", avg_o, 0);
    chk("rst_period", period_o, 0);
    chk("rst_pvalid", period_valid_o, 0);
    chk("rst_mvalid", meas_valid_o, 0);
    chk("rst_state", 32'(dut.u_cross.state), 32'(WAIT_LOW));
    @(negedge clk);
    rst = 1'b1;

    // Ramp 0..15 with idle gaps between some samples
    pulse_base = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      send(12'(i));
      if (i == 14) chk("ramp_no_early_pulse", meas_valid_o, 0);
      if (i % 2 == 1 && i < 15) idle();
    end
    chk("ramp_mvalid", meas_valid_o, 1);
    chk("ramp_min", min_o, 0);
    chk("ramp_max", max_o, 15);
    chk("ramp_p2p", p2p_o, 15);
    chk("ramp_avg", avg_o, 7);
    idle();
    chk("ramp_pulse_width", meas_valid_o, 0);
    chk("ramp_hold_max", max_o, 15);
    chk("ramp_pulse_count", pulse_cnt - pulse_base, 1);

    // Constant 2048 for three windows
    do_reset(1);
    level = 12'd2000;
    pulse_base = pulse_cnt;
    for (int i = 0; i < 48; i++) send(12'd2048);
    chk("const_mvalid", meas_valid_o, 1);
    idle();
    chk("const_pulses", pulse_cnt - pulse_base, 3);
    chk("const_min", min_o, 2048);
    chk("const_max", max_o, 2048);
    chk("const_avg", avg_o, 2048);
    chk("const_p2p", p2p_o, 0);
    chk("const_pvalid", period_valid_o, 0);

    // Square wave 0/4000, 10 samples per half; ends on a rising crossing sample
    do_reset(1);
    level = 12'd2000;
    for (int i = 0; i <= 50; i++) begin
      send(((i / 10) % 2 == 1) ? 12'd4000 : 12'd0);
      if (i == 10) chk("sq_first_cross_pvalid", period_valid_o, 0);
      if (i == 30) begin
        chk("sq_period_30", period_o, 20);
        chk("sq_pvalid_30", period_valid_o, 1);
      end
    end
    chk("sq_period_50", period_o, 20);
    chk("sq_state_50", 32'(dut.u_cross.state), 32'(COUNT_LOW));

    // Input held at 0: timeout fires on the 65535th zero
    for (int i = 0; i < 65534; i++) send(12'd0);
    chk("to_pre_pvalid", period_valid_o, 1);
    chk("to_pre_state", 32'(dut.u_cross.state), 32'(COUNT_HIGH));
    send(12'd0);
    chk("to_period", period_o, 0);
    chk("to_pvalid", period_valid_o, 0);
    chk("to_state", 32'(dut.u_cross.state), 32'(WAIT_LOW));

    // Noise of +/-10 around level, then exact-threshold crossings
    do_reset(1);
    level = 12'd2000;
    send(12'd0);
    for (int i = 0; i < 40; i++) send((i % 2 == 1) ? 12'd2010 : 12'd1990);
    chk("noise_pvalid", period_valid_o, 0);
    chk("noise_state", 32'(dut.u_cross.state), 32'(WAIT_HIGH_FIRST));
    send(12'd2016);
    send(12'd1984);
    send(12'd2000);
    send(12'd2016);
    chk("edge_period", period_o, 3);
    chk("edge_pvalid", period_valid_o, 1);

    // Upper threshold saturation
    do_reset(1);
    level = 12'd4090;
    send(12'd4074);
    send(12'd4095);
    send(12'd4074);
    send(12'd4095);
    chk("sat_hi_period", period_o, 2);
    chk("sat_hi_pvalid", period_valid_o, 1);

    // Lower threshold saturation
    do_reset(1);
    level = 12'd5;
    send(12'd0);
    send(12'd21);
    send(12'd0);
    send(12'd21);
    chk("sat_lo_period", period_o, 2);
    chk("sat_lo_pvalid", period_valid_o, 1);

    // Reset one cycle at sample 7 of a window discards it
    do_reset(1);
    level = 12'd2000;
    for (int i = 0; i < 7; i++) send(12'd100);
    do_reset(1);
    pulse_base = pulse_cnt;
    for (int i = 0; i < 15; i++) send(12'd50);
    idle();
    chk("midrst_no_pulse", pulse_cnt - pulse_base, 0);
    chk("midrst_min_reset", min_o, 0);
    send(12'd50);
    chk("midrst_mvalid", meas_valid_o, 1);
    chk("midrst_min", min_o, 50);
    chk("midrst_max", max_o, 50);
    chk("midrst_avg", avg_o, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
